// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus: registered pipeline fields in, ID read ports,
// forwarding value and retire counter out.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              reg_write_in;
    logic              mem_to_reg_in;
    logic [DATA_W-1:0] read_data_in;
    logic [ADDR_W-1:0] mux_reg_dst_out_in;
    logic [DATA_W-1:0] ALU_result_in;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] wb_data_out;
    logic              wb_valid_out;
    logic [31:0]       retire_count;

    modport master (
        output reg_write_in, mem_to_reg_in, read_data_in, mux_reg_dst_out_in, ALU_result_in,
        output read_reg1, read_reg2,
        input  read_data1, read_data2, wb_data_out, wb_valid_out, retire_count
    );

    modport slave (
        input  reg_write_in, mem_to_reg_in, read_data_in, mux_reg_dst_out_in, ALU_result_in,
        input  read_reg1, read_reg2,
        output read_data1, read_data2, wb_data_out, wb_valid_out, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU data, commits it to a 32-entry register file with
// write-through bypass to the two ID read ports, and counts retired writes.
module wb_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [31:0]       retire_q;
    logic [31:0]       retire_d;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    always_comb begin
        wb_data  = '0;
        wb_valid = 1'b0;
        if (rst) begin
            wb_data  = bus.mem_to_reg_in ? bus.read_data_in : bus.ALU_result_in;
            wb_valid = bus.reg_write_in && (bus.mux_reg_dst_out_in != '0);
        end
    end

    // Bypass only when the write actually commits, so r0 and idle cycles fall through.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rst) begin
            if (bus.read_reg1 != '0) begin
                if (wb_valid && (bus.read_reg1 == bus.mux_reg_dst_out_in)) rd1 = wb_data;
                else                                                       rd1 = regs_q[bus.read_reg1];
            end
            if (bus.read_reg2 != '0) begin
                if (wb_valid && (bus.read_reg2 == bus.mux_reg_dst_out_in)) rd2 = wb_data;
                else                                                       rd2 = regs_q[bus.read_reg2];
            end
        end
    end

    always_comb begin
        retire_d = retire_q;
        if (bus.reg_write_in) retire_d = retire_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_valid) begin
            regs_q[bus.mux_reg_dst_out_in] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_q <= '0;
        else      retire_q <= retire_d;
    end

    assign bus.wb_data_out  = wb_data;
    assign bus.wb_valid_out = wb_valid;
    assign bus.read_data1   = rd1;
    assign bus.read_data2   = rd2;
    assign bus.retire_count = retire_q;
endmodule
